// File: rtl/ldpcenc_shsched.sv
// ldpcenc_shsched: shift scheduler for the LDPC encoder parity-accumulation
// stage. Walks the prototype matrix row by row, feeds table shift entries and
// info sub-blocks into the external 81-bit right cyclic shifter, XOR-folds
// the shifter output into one row sum per matrix row, and hands each row sum
// downstream.
//
// Handshake (out_valid/out_ready): a row sum transfers on any rising edge
// where out_valid and out_ready are both high. Once out_valid rises, it and
// out_data stay unchanged until that transfer happens; out_ready is ignored
// while out_valid is low.
//
// Pipeline: RUN issues one {row,col} fetch per cycle. Table and buffer answer
// one cycle later, tracked by the fetch-valid flag v1_q. DRAIN exists only to
// fold in the last column's data before the row sum is presented in OUT.
module ldpcenc_shsched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  ncol,
  input  logic [3:0]  nrow,
  input  logic [1:0]  zsel,
  output logic [8:0]  tbl_addr,
  input  logic [7:0]  tbl_data,
  output logic [4:0]  buf_addr,
  input  logic [80:0] buf_data,
  output logic [80:0] rcs_din,
  output logic        rcs_z54,
  output logic [7:0]  rcs_sh,
  input  logic [80:0] rcs_dout,
  output logic [80:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [80:0] MASK_Z27 = {54'd0, {27{1'b1}}};
  localparam logic [80:0] MASK_Z54 = {27'd0, {54{1'b1}}};
  localparam logic [80:0] MASK_Z81 = {81{1'b1}};

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [4:0]  ncol_q, ncol_d;
  logic [3:0]  nrow_q, nrow_d;
  logic [1:0]  zsel_q, zsel_d;
  logic        v1_q, v1_d;
  logic        first_q, first_d;
  logic [80:0] acc_q, acc_d;
  logic [80:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;

  logic [80:0] z_mask;
  logic        last_col;
  logic        last_row;
  logic        out_fire;

  // Keep-mask for the latched sub-block size; code 3 behaves as Z = 81.
  always_comb begin
    z_mask = MASK_Z81;
    unique case (zsel_q)
      2'd0:    z_mask = MASK_Z27;
      2'd1:    z_mask = MASK_Z54;
      default: z_mask = MASK_Z81;
    endcase
  end

  assign last_col = (col_q == (ncol_q - 5'd1));
  assign last_row = (row_q == (nrow_q - 4'd1));
  assign out_fire = out_valid_q & out_ready;

  // Fetch addresses follow the walk position; shifter inputs are only live
  // in the cycle the fetched data is valid, otherwise they sit at zero.
  assign tbl_addr  = {row_q, col_q};
  assign buf_addr  = col_q;
  assign rcs_din   = v1_q ? buf_data : 81'd0;
  assign rcs_sh    = v1_q ? tbl_data : 8'h00;
  assign rcs_z54   = (state_q != S_IDLE) && (zsel_q == 2'd1);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  // Next-state logic: matrix walk, row-sum accumulation and output handshake.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    ncol_d      = ncol_q;
    nrow_d      = nrow_q;
    zsel_d      = zsel_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    v1_d        = 1'b0;
    first_d     = 1'b0;

    // The first column of a row overwrites the previous row's sum; an absent
    // entry makes the shifter output zero, which leaves the sum untouched.
    if (v1_q) begin
      acc_d = first_q ? rcs_dout : (acc_q ^ rcs_dout);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((ncol == 5'd0) || (nrow == 4'd0)) begin
            // Empty matrix: nothing to walk, just acknowledge.
            done_d = 1'b1;
          end else begin
            ncol_d  = ncol;
            nrow_d  = nrow;
            zsel_d  = zsel;
            row_d   = 4'd0;
            col_d   = 5'd0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        v1_d    = 1'b1;
        first_d = (col_q == 5'd0);
        if (last_col) begin
          col_d   = 5'd0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + 5'd1;
        end
      end

      S_DRAIN: begin
        // acc_d already holds the last column, so the row sum is complete.
        out_data_d  = acc_d & z_mask;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_data_d  = 81'd0;
          if (last_row) begin
            row_d   = 4'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = S_RUN;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register: FSM, walk position, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= 4'd0;
      col_q       <= 5'd0;
      ncol_q      <= 5'd0;
      nrow_q      <= 4'd0;
      zsel_q      <= 2'd0;
      v1_q        <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= 81'd0;
      out_data_q  <= 81'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ncol_q      <= ncol_d;
      nrow_q      <= nrow_d;
      zsel_q      <= zsel_d;
      v1_q        <= v1_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ldpcenc_shsched.sv
// Testbench for ldpcenc_shsched: behavioural prototype table, info buffer and
// cyclic shifter around the DUT, plus a row-sum scoreboard.
module tb_ldpcenc_shsched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  ncol;
  logic [3:0]  nrow;
  logic [1:0]  zsel;
  logic [8:0]  tbl_addr;
  logic [7:0]  tbl_data;
  logic [4:0]  buf_addr;
  logic [80:0] buf_data;
  logic [80:0] rcs_din;
  logic        rcs_z54;
  logic [7:0]  rcs_sh;
  logic [80:0] rcs_dout;
  logic [80:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  logic [7:0]  tbl_mem [0:511];
  logic [80:0] buf_mem [0:31];
  logic [80:0] exp_q[$];

  int tests = 0;
  int fails = 0;

  ldpcenc_shsched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ncol      (ncol),
    .nrow      (nrow),
    .zsel      (zsel),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .rcs_din   (rcs_din),
    .rcs_z54   (rcs_z54),
    .rcs_sh    (rcs_sh),
    .rcs_dout  (rcs_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  // ---------------- models ----------------
  // Right cyclic shift over Z = 54 or 81; Z = 27 data is replicated so an
  // 81-bit rotation is equivalent. Absent entries give zero.
  function automatic logic [80:0] rot(input logic [80:0] d, input logic [7:0] sh,
                                      input logic z54);
    logic [80:0] r;
    int n;
    int s;
    r = '0;
    if (sh[7]) begin
      n = z54 ? 54 : 81;
      s = int'(sh[6:0]) % n;
      for (int i = 0; i < n; i++) r[i] = d[(i + s) % n];
    end
    return r;
  endfunction

  function automatic logic [80:0] zmask(input int zs);
    logic [80:0] m;
    m = '1;
    if (zs == 0) m = {54'd0, {27{1'b1}}};
    else if (zs == 1) m = {27'd0, {54{1'b1}}};
    return m;
  endfunction

  function automatic logic [80:0] rand_buf(input int zs);
    logic [95:0] r;
    logic [80:0] v;
    r = {$urandom, $urandom, $urandom};
    v = r[80:0];
    if (zs == 0) v = {3{r[26:0]}};
    else if (zs == 1) v = {27'd0, r[53:0]};
    return v;
  endfunction

  always_comb rcs_dout = rot(rcs_din, rcs_sh, rcs_z54);

  // Table and buffer RAMs, one-cycle read latency.
  always @(posedge clk) begin
    tbl_data <= tbl_mem[tbl_addr];
    buf_data <= buf_mem[buf_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},      81'(busy),      81'(0));
    check({tag, "_done"},      81'(done),      81'(0));
    check({tag, "_out_valid"}, 81'(out_valid), 81'(0));
    check({tag, "_out_data"},  out_data,       81'(0));
    check({tag, "_tbl_addr"},  81'(tbl_addr),  81'(0));
    check({tag, "_buf_addr"},  81'(buf_addr),  81'(0));
    check({tag, "_rcs_sh"},    81'(rcs_sh),    81'(0));
    check({tag, "_rcs_z54"},   81'(rcs_z54),   81'(0));
    check({tag, "_state"},     81'(state_dbg), 81'(0));
  endtask

  // ---------------- drivers ----------------
  // Load random table/buffer contents and push the golden row sums.
  task automatic setup_cw(input int nc, input int nr, input int zs, input bit present);
    int z;
    logic [7:0]  e;
    logic [80:0] a;
    z = (zs == 0) ? 27 : ((zs == 1) ? 54 : 81);
    for (int i = 0; i < 512; i++) tbl_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) buf_mem[i] = '0;
    for (int c = 0; c < nc; c++) buf_mem[c] = rand_buf(zs);
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        e[6:0] = 7'($urandom_range(0, z - 1));
        e[7]   = present && ($urandom_range(0, 3) != 0);
        tbl_mem[r * 32 + c] = e;
      end
    end
    for (int r = 0; r < nr; r++) begin
      a = '0;
      for (int c = 0; c < nc; c++) a = a ^ rot(buf_mem[c], tbl_mem[r * 32 + c], zs == 1);
      exp_q.push_back(a & zmask(zs));
    end
  endtask

  // Drives start in cycle 0 (the cycle whose closing edge samples it).
  task automatic pulse_start(input int nc, input int nr, input int zs);
    @(negedge clk);
    start = 1'b1;
    ncol  = 5'(nc);
    nrow  = 4'(nr);
    zsel  = 2'(zs);
  endtask

  // Runs one codeword from cycle 1 until done, optionally holding out_ready
  // low for bp cycles in each OUT and re-pulsing start at cycle poke.
  task automatic run_cw(input int nc, input int nr, input int zs, input int bp,
                        input int poke, input string tag);
    int first_valid;
    int done_cyc;
    int hold;
    int exp_done;
    logic busy_at_done;
    logic [80:0] held;
    logic [80:0] e;
    exp_done     = nr * (nc + 2 + bp) + 1;
    first_valid  = -1;
    done_cyc     = -1;
    hold         = 0;
    busy_at_done = 1'b1;
    held         = '0;
    out_ready    = (bp == 0);
    for (int k = 1; k <= exp_done + 30 && done_cyc < 0; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (k == 1) begin
        // Config inputs wander while busy; the latched copy must rule.
        ncol = 5'($urandom_range(0, 31));
        nrow = 4'($urandom_range(0, 15));
        zsel = 2'($urandom_range(0, 3));
        check({tag, "_z54"}, 81'(rcs_z54), 81'(zs == 1));
      end
      if (out_valid && first_valid < 0) first_valid = k;
      if (done) begin
        done_cyc     = k;
        busy_at_done = busy;
      end
      if (out_valid) begin
        if (hold < bp) begin
          out_ready = 1'b0;
          if (hold == 0) held = out_data;
          else check({tag, "_bp_stable"}, out_data, held);
          check({tag, "_no_fetch"}, 81'(rcs_sh), 81'(0));
          hold++;
        end else begin
          out_ready = 1'b1;
          hold      = 0;
          if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 81'(exp_q.size()), 81'(1));
          end else begin
            e = exp_q.pop_front();
            check({tag, "_row_sum"}, out_data, e);
          end
        end
      end else begin
        out_ready = (bp == 0);
      end
    end
    start = 1'b0;
    check({tag, "_first_valid"}, 81'(first_valid), 81'(nc + 2));
    check({tag, "_done_cycle"}, 81'(done_cyc), 81'(exp_done));
    check({tag, "_busy_at_done"}, 81'(busy_at_done), 81'(0));
    check({tag, "_sb_empty"}, 81'(exp_q.size()), 81'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [80:0] e1;
    rst       = 1'b1;
    start     = 1'b0;
    ncol      = 5'd0;
    nrow      = 4'd0;
    zsel      = 2'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 512; i++) tbl_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) buf_mem[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Single entry: shift 1 of bit 0 at Z = 81 lands on bit 80.
    for (int i = 0; i < 512; i++) tbl_mem[i] = 8'h00;
    tbl_mem[0] = 8'h81;
    buf_mem[0] = 81'd1;
    e1 = '0;
    e1[80] = 1'b1;
    exp_q.push_back(e1);
    pulse_start(1, 1, 2);
    run_cw(1, 1, 2, 0, -1, "single");

    // Rate 1/2 at Z = 54.
    setup_cw(12, 12, 1, 1'b1);
    pulse_start(12, 12, 1);
    run_cw(12, 12, 1, 0, -1, "r12_z54");

    // All entries absent at Z = 27: every row sum is zero.
    setup_cw(20, 4, 0, 1'b0);
    pulse_start(20, 4, 0);
    run_cw(20, 4, 0, 0, -1, "absent");

    // Backpressure of 5 cycles in every OUT, rate 2/3 at Z = 81.
    setup_cw(16, 8, 2, 1'b1);
    pulse_start(16, 8, 2);
    run_cw(16, 8, 2, 5, -1, "backpressure");

    // Start re-pulsed while busy is ignored.
    setup_cw(3, 2, 1, 1'b1);
    pulse_start(3, 2, 1);
    run_cw(3, 2, 1, 0, 2, "start_busy");

    // Zero-column request: done next cycle, never busy.
    pulse_start(0, 3, 2);
    check("ncol0_busy_c0", 81'(busy), 81'(0));
    @(negedge clk);
    start = 1'b0;
    check("ncol0_done_c1", 81'(done), 81'(1));
    check("ncol0_busy_c1", 81'(busy), 81'(0));
    @(negedge clk);
    check("ncol0_done_c2", 81'(done), 81'(0));
    check("ncol0_busy_c2", 81'(busy), 81'(0));

    // Reset in cycle 7 of a 12x12 run, then a fresh codeword.
    setup_cw(12, 12, 1, 1'b1);
    pulse_start(12, 12, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_busy_before", 81'(busy), 81'(1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_done", 81'(done), 81'(0));
    end
    setup_cw(12, 12, 1, 1'b1);
    pulse_start(12, 12, 1);
    run_cw(12, 12, 1, 0, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
